signal_period_meter: RTL and testbench

SIGNAL_PERIOD_METER -- requirements
Module: Signal_Period_Meter

---
 rtl/signal_period_meter.sv | 131 +++++++++++++
 tb/tb_signal_period_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/signal_period_meter.sv
// Measures period and high time of a clock-synchronous periodic signal, edge to edge,
// with a ready/valid output holding register, stall detection and a sticky loss flag.
module signal_period_meter #(
    parameter int WORD_WIDTH   = 16,
    parameter int STALL_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  signal_in,
    output logic [WORD_WIDTH-1:0] period,
    output logic [WORD_WIDTH-1:0] high_time,
    output logic                  measurement_valid,
    input  logic                  measurement_ready,
    output logic                  stalled,
    output logic                  measurement_lost
);

    localparam logic [WORD_WIDTH-1:0] ONE         = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] STALL_LIMIT = WORD_WIDTH'(STALL_CYCLES);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  prev_q, prev_d;
    logic [WORD_WIDTH-1:0] period_count_q, period_count_d;
    logic [WORD_WIDTH-1:0] high_count_q, high_count_d;
    logic [WORD_WIDTH-1:0] period_q, period_d;
    logic [WORD_WIDTH-1:0] high_time_q, high_time_d;
    logic                  valid_q, valid_d;
    logic                  stalled_q, stalled_d;
    logic                  lost_q, lost_d;

    logic                  rise;
    logic                  capture;
    logic                  hold;
    logic                  accept;

    // prev resets to 1 so a line already high out of reset is not seen as an edge.
    assign rise   = signal_in & ~prev_q;
    assign prev_d = signal_in;

    always_comb begin
        state_d        = state_q;
        period_count_d = period_count_q;
        high_count_d   = high_count_q;
        stalled_d      = stalled_q;
        capture        = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    period_count_d = ONE;
                    high_count_d   = ONE;
                    stalled_d      = 1'b0;
                    state_d        = MEASURE;
                end
            end
            MEASURE: begin
                // An edge landing exactly on the stall limit still counts as a valid period.
                if (rise) begin
                    capture        = 1'b1;
                    period_count_d = ONE;
                    high_count_d   = ONE;
                end else if (period_count_q == STALL_LIMIT) begin
                    stalled_d = 1'b1;
                    state_d   = WAIT_FIRST;
                end else begin
                    period_count_d = period_count_q + ONE;
                    high_count_d   = high_count_q + WORD_WIDTH'(signal_in);
                end
            end
            default: begin
                state_d = WAIT_FIRST;
            end
        endcase
    end

    assign hold   = valid_q & ~measurement_ready;
    assign accept = valid_q & measurement_ready;

    always_comb begin
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = valid_q;
        lost_d      = lost_q;
        if (hold) begin
            if (capture) begin
                lost_d = 1'b1;
            end
        end else if (capture) begin
            period_d    = period_count_q;
            high_time_d = high_count_q;
            valid_d     = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= WAIT_FIRST;
            prev_q         <= 1'b1;
            period_count_q <= '0;
            high_count_q   <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            valid_q        <= 1'b0;
            stalled_q      <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            period_count_q <= period_count_d;
            high_count_q   <= high_count_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            valid_q        <= valid_d;
            stalled_q      <= stalled_d;
            lost_q         <= lost_d;
        end
    end

    assign period            = period_q;
    assign high_time         = high_time_q;
    assign measurement_valid = valid_q;
    assign stalled           = stalled_q;
    assign measurement_lost  = lost_q;

endmodule

// File: tb/tb_signal_period_meter.sv
// Directed and randomized checks of signal_period_meter against a sample-history reference model.
module tb_signal_period_meter;

    localparam int W     = 16;
    localparam int STALL = 20;

    logic         clock;
    logic         clear;
    logic         signal_in;
    logic         measurement_ready;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         measurement_valid;
    logic         stalled;
    logic         measurement_lost;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: samples seen since the last reference edge, plus output state.
    int q[$];
    bit armed;
    bit m_prev;
    bit m_valid;
    bit m_stalled;
    bit m_lost;
    int m_period;
    int m_high;

    signal_period_meter #(
        .WORD_WIDTH  (W),
        .STALL_CYCLES(STALL)
    ) dut (
        .clock            (clock),
        .clear            (clear),
        .signal_in        (signal_in),
        .period           (period),
        .high_time        (high_time),
        .measurement_valid(measurement_valid),
        .measurement_ready(measurement_ready),
        .stalled          (stalled),
        .measurement_lost (measurement_lost)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit sig, input bit rdy, input bit clr);
        bit rise;
        bit cap;
        int cp;
        int ch;
        cap = 0;
        cp  = 0;
        ch  = 0;
        if (clr) begin
            q.delete();
            armed     = 0;
            m_prev    = 1;
            m_valid   = 0;
            m_stalled = 0;
            m_lost    = 0;
            m_period  = 0;
            m_high    = 0;
            return;
        end
        rise = sig && !m_prev;
        if (!armed) begin
            if (rise) begin
                armed     = 1;
                m_stalled = 0;
                q.delete();
                q.push_back(int'(sig));
            end
        end else if (rise) begin
            cap = 1;
            cp  = q.size();
            foreach (q[i]) ch += q[i];
            q.delete();
            q.push_back(int'(sig));
        end else if (q.size() == STALL) begin
            armed     = 0;
            m_stalled = 1;
            q.delete();
        end else begin
            q.push_back(int'(sig));
        end
        if (m_valid && !rdy) begin
            if (cap) m_lost = 1;
        end else if (cap) begin
            m_period = cp;
            m_high   = ch;
            m_valid  = 1;
        end else if (m_valid) begin
            m_valid = 0;
        end
        m_prev = sig;
    endtask

    task automatic cycle(input bit sig, input bit rdy, input bit clr);
        signal_in         = sig;
        measurement_ready = rdy;
        clear             = clr;
        @(posedge clock);
        model_step(sig, rdy, clr);
        #1;
        check("period", 32'(period), 32'(m_period));
        check("high_time", 32'(high_time), 32'(m_high));
        check("valid", 32'(measurement_valid), 32'(m_valid));
        check("stalled", 32'(stalled), 32'(m_stalled));
        check("lost", 32'(measurement_lost), 32'(m_lost));
        $display("t=%0t clr=%0b sig=%0b rdy=%0b -> period=%0d high=%0d valid=%0b stalled=%0b lost=%0b",
                 $time, clr, sig, rdy, period, high_time, measurement_valid, stalled, measurement_lost);
    endtask

    task automatic run_wave(input int hi, input int lo, input int reps, input bit rdy);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) cycle(1'b1, rdy, 1'b0);
            for (int i = 0; i < lo; i++) cycle(1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        clear             = 1'b1;
        signal_in         = 1'b0;
        measurement_ready = 1'b0;

        // Reset state, then quiet input: no stall may appear while waiting for a first edge.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_period", 32'(period), 32'd0);
        check("reset_valid", 32'(measurement_valid), 32'd0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check("no_stall_idle", 32'(stalled), 32'd0);

        // 2 high / 2 low with ready held high.
        cycle(1'b1, 1'b1, 1'b0);
        check("first_edge_no_out", 32'(measurement_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("p4_period", 32'(period), 32'd4);
        check("p4_high", 32'(high_time), 32'd2);
        check("p4_valid", 32'(measurement_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        check("p4_valid_drop", 32'(measurement_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run_wave(2, 2, 3, 1'b1);

        // Minimum period: 1 high / 1 low.
        run_wave(1, 1, 6, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("p2_period", 32'(period), 32'd2);
        check("p2_high", 32'(high_time), 32'd1);

        // Signal already high as clear releases: that level is not an edge.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        run_wave(0, 3, 1, 1'b1);
        run_wave(3, 3, 1, 1'b1);
        check("hi_release_no_out", 32'(measurement_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        check("p6_period", 32'(period), 32'd6);
        check("p6_high", 32'(high_time), 32'd3);

        // Backpressure: first capture held, second dropped, then accepted.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        run_wave(2, 3, 2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("held_valid", 32'(measurement_valid), 32'd1);
        check("held_period", 32'(period), 32'd5);
        check("lost_flag", 32'(measurement_lost), 32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("accepted_valid", 32'(measurement_valid), 32'd0);
        check("lost_sticky", 32'(measurement_lost), 32'd1);

        // Stall: edge then long low; next edge rearms silently, following edge measures.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 1'b0);
        check("stalled_set", 32'(stalled), 32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        check("stall_cleared", 32'(stalled), 32'd0);
        check("stall_no_out", 32'(measurement_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("post_stall_period", 32'(period), 32'd3);
        check("post_stall_high", 32'(high_time), 32'd1);

        // Clear mid-period while a measurement is held.
        run_wave(2, 2, 2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("pre_clear_valid", 32'(measurement_valid), 32'd1);
        cycle(1'b1, 1'b0, 1'b1);
        check("clr_period", 32'(period), 32'd0);
        check("clr_valid", 32'(measurement_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("clr_wait_first", 32'(measurement_valid), 32'd0);

        // Randomized periods (some beyond the stall limit), random ready, rare clears.
        for (int k = 0; k < 60; k++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 14));
            for (int i = 0; i < hi + lo; i++) begin
                cycle((i < hi) ? 1'b1 : 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
